// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: oversampling factors, receiver state encoding and
// the bit-timer reload helper used by the receiver.
package uart_rx_pkg;

   localparam int OVERSAMPLE = 8;
   localparam int HALF_BIT   = 4;
   localparam int TIMER_W    = 19;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   // Reload value for the down-counting bit timer: factor * p - 1 clocks.
   function automatic logic [TIMER_W-1:0] bit_ticks(input logic [15:0] p, input int factor);
      return TIMER_W'(p) * TIMER_W'(factor) - TIMER_W'(1);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high lines do not look active out of reset.
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8x-oversampling UART receiver (8N1-style, DATA_WIDTH data bits, LSB first)
// presenting each word on a single-entry AXI-stream output register.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [DATA_WIDTH-1:0] output_axis_tdata,
   output logic                  output_axis_tvalid,
   input  logic                  output_axis_tready,
   input  logic                  rxd,
   output logic                  busy,
   output logic                  overrun_error,
   output logic                  frame_error,
   input  logic [15:0]           prescale
);

   localparam int IDX_W = 4;

   logic                  rxd_sync;
   rx_state_e             state_q, state_d;
   logic [TIMER_W-1:0]    timer_q, timer_d;
   logic [15:0]           p_q, p_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  ovr_q, ovr_d;
   logic                  fe_q, fe_d;
   logic                  expired;

   uart_rx_sync #(
      .RESET_VAL(1'b1)
   ) u_rxd_sync (
      .clk(clk),
      .rst(rst),
      .d_i(rxd),
      .q_o(rxd_sync)
   );

   assign expired = (timer_q == '0);

   always_comb begin
      state_d  = state_q;
      timer_d  = expired ? timer_q : timer_q - TIMER_W'(1);
      p_d      = p_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q & ~output_axis_tready;
      ovr_d    = 1'b0;
      fe_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rxd_sync) begin
               p_d     = (prescale == 16'd0) ? 16'd1 : prescale;
               timer_d = bit_ticks(p_d, HALF_BIT);
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (expired) begin
               if (rxd_sync) begin
                  state_d = ST_IDLE;
               end else begin
                  timer_d = bit_ticks(p_q, OVERSAMPLE);
                  idx_d   = '0;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (expired) begin
               shift_d = {rxd_sync, shift_q[DATA_WIDTH-1:1]};
               timer_d = bit_ticks(p_q, OVERSAMPLE);
               if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_STOP: begin
            // Returning to IDLE here re-arms at mid stop bit, so a start bit
            // that immediately follows is not missed.
            if (expired) begin
               if (rxd_sync) begin
                  tdata_d  = shift_q;
                  tvalid_d = 1'b1;
                  ovr_d    = tvalid_q & ~output_axis_tready;
                  state_d  = ST_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rxd_sync) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         p_q      <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         ovr_q    <= 1'b0;
         fe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         p_q      <= p_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         ovr_q    <= ovr_d;
         fe_q     <= fe_d;
      end
   end

   assign output_axis_tdata  = tdata_q;
   assign output_axis_tvalid = tvalid_q;
   assign overrun_error      = ovr_q;
   assign frame_error        = fe_q;
   assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a serial line driver plays the transmitter and
// a monitor logs accepted beats and error pulses for the scenario tasks.
module tb_uart_rx;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rxd = 1'b1;
   logic          tready = 1'b1;
   logic [15:0]   prescale = 16'd1;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          busy;
   logic          ovr;
   logic          fe;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ovr_cnt = 0;
   int fe_cnt = 0;
   logic [7:0] beat_data[$];
   int         beat_cyc[$];

   uart_rx #(
      .DATA_WIDTH(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .output_axis_tdata(tdata),
      .output_axis_tvalid(tvalid),
      .output_axis_tready(tready),
      .rxd(rxd),
      .busy(busy),
      .overrun_error(ovr),
      .frame_error(fe),
      .prescale(prescale)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tvalid && tready) begin
         beat_data.push_back(tdata);
         beat_cyc.push_back(cyc);
         $display("[%0d] rx beat data=%02h", cyc, tdata);
      end
      if (ovr) ovr_cnt++;
      if (fe) fe_cnt++;
   end

   function automatic logic [7:0] beat_at(input int i);
      return (beat_data.size() > i) ? beat_data[i] : 8'hxx;
   endfunction

   function automatic int cyc_at(input int i);
      return (beat_cyc.size() > i) ? beat_cyc[i] : -1;
   endfunction

   task automatic clear_beats();
      beat_data.delete();
      beat_cyc.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at the current negedge; each bit lasts 8*p clocks.
   task automatic send_frame(input logic [7:0] d, input int p, input logic stop_bit, output int t0);
      logic [9:0] bits;
      bits = {stop_bit, d, 1'b0};
      t0 = cyc;
      $display("[%0d] tx frame data=%02h p=%0d stop=%0b", cyc, d, p, stop_bit);
      for (int i = 0; i < 10; i++) begin
         rxd = bits[i];
         repeat (8 * p) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
      checks++; if (tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 00", tdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if ({ovr, fe} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b expected 00", {ovr, fe}); end
   endtask

   task automatic test_basic();
      int t0, f0, o0;
      f0 = fe_cnt; o0 = ovr_cnt;
      prescale = 16'd1; tready = 1'b1; clear_beats();
      send_frame(8'h5A, 1, 1'b1, t0);
      idle(16);
      checks++; if (beat_data.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", beat_data.size()); end
      checks++; if (beat_at(0) !== 8'h5A) begin errors++; $display("FAIL basic_data: got %h expected 5a", beat_at(0)); end
      checks++; if (cyc_at(0) - t0 !== 79) begin errors++; $display("FAIL basic_latency: got %0d expected 79", cyc_at(0) - t0); end
      checks++; if ((fe_cnt - f0) + (ovr_cnt - o0) !== 0) begin errors++; $display("FAIL basic_errs: got %0d expected 0", (fe_cnt - f0) + (ovr_cnt - o0)); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
      // prescale of zero must behave exactly like one
      prescale = 16'd0; clear_beats();
      send_frame(8'hC3, 1, 1'b1, t0);
      idle(16);
      checks++; if (beat_at(0) !== 8'hC3) begin errors++; $display("FAIL p0_data: got %h expected c3", beat_at(0)); end
      checks++; if (cyc_at(0) - t0 !== 79) begin errors++; $display("FAIL p0_latency: got %0d expected 79", cyc_at(0) - t0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v [4];
      int t0, tdummy;
      v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h80; v[3] = 8'h01;
      prescale = 16'd4; tready = 1'b1; clear_beats();
      send_frame(v[0], 4, 1'b1, t0);
      for (int i = 1; i < 4; i++) send_frame(v[i], 4, 1'b1, tdummy);
      idle(64);
      checks++; if (beat_data.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", beat_data.size()); end
      checks++; if (cyc_at(0) - t0 !== 307) begin errors++; $display("FAIL b2b_latency: got %0d expected 307", cyc_at(0) - t0); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (beat_at(i) !== v[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, beat_at(i), v[i]); end
      end
      for (int i = 1; i < 4; i++) begin
         checks++; if (cyc_at(i) - cyc_at(i - 1) !== 320) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 320", i, cyc_at(i) - cyc_at(i - 1)); end
      end
   endtask

   task automatic test_overrun();
      int t0, o0;
      prescale = 16'd1; tready = 1'b0; clear_beats();
      o0 = ovr_cnt;
      send_frame(8'h11, 1, 1'b1, t0);
      idle(20);
      send_frame(8'h22, 1, 1'b1, t0);
      idle(20);
      checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - o0); end
      checks++; if (tdata !== 8'h22) begin errors++; $display("FAIL ovr_tdata: got %h expected 22", tdata); end
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL ovr_tvalid: got %b expected 1", tvalid); end
      tready = 1'b1;
      @(negedge clk);
      tready = 1'b0;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b expected 0", tvalid); end
      tready = 1'b1;
      idle(4);
      clear_beats();
   endtask

   task automatic test_frame_break();
      int t0, f0;
      prescale = 16'd1; tready = 1'b1; clear_beats();
      f0 = fe_cnt;
      send_frame(8'h33, 1, 1'b0, t0);
      rxd = 1'b1;
      idle(30);
      checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL fe_pulses: got %0d expected 1", fe_cnt - f0); end
      checks++; if (beat_data.size() !== 0) begin errors++; $display("FAIL fe_no_beat: got %0d expected 0", beat_data.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_busy: got %b expected 0", busy); end
      rxd = 1'b0;
      idle(40 * 8);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy: got %b expected 1", busy); end
      rxd = 1'b1;
      idle(20);
      checks++; if (fe_cnt - f0 !== 2) begin errors++; $display("FAIL brk_pulses: got %0d expected 2", fe_cnt - f0); end
      send_frame(8'h44, 1, 1'b1, t0);
      idle(20);
      checks++; if (beat_at(0) !== 8'h44 || beat_data.size() !== 1) begin errors++; $display("FAIL brk_next: got %h (n=%0d) expected 44 (n=1)", beat_at(0), beat_data.size()); end
      checks++; if (fe_cnt - f0 !== 2) begin errors++; $display("FAIL brk_final_pulses: got %0d expected 2", fe_cnt - f0); end
   endtask

   task automatic test_glitch();
      prescale = 16'd2; clear_beats();
      rxd = 1'b0;
      idle(4);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", busy); end
      rxd = 1'b1;
      idle(100);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b expected 0", busy); end
      checks++; if (beat_data.size() !== 0) begin errors++; $display("FAIL glitch_no_beat: got %0d expected 0", beat_data.size()); end
   endtask

   task automatic test_reset_mid();
      int t0;
      prescale = 16'd1; tready = 1'b0; clear_beats();
      send_frame(8'h5A, 1, 1'b1, t0);
      rxd = 1'b0; idle(8);
      rxd = 1'b1; idle(8);
      rxd = 1'b0; idle(4);
      checks++; if ({busy, tvalid} !== 2'b11) begin errors++; $display("FAIL rstmid_pre: got %b expected 11", {busy, tvalid}); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({tvalid, busy, ovr, fe} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b expected 0000", {tvalid, busy, ovr, fe}); end
      checks++; if (tdata !== '0) begin errors++; $display("FAIL rstmid_tdata: got %h expected 00", tdata); end
      rst = 1'b0; rxd = 1'b1; tready = 1'b1;
      idle(40);
      clear_beats();
      send_frame(8'hA5, 1, 1'b1, t0);
      idle(20);
      checks++; if (beat_at(0) !== 8'hA5 || beat_data.size() !== 1) begin errors++; $display("FAIL rstmid_next: got %h (n=%0d) expected a5 (n=1)", beat_at(0), beat_data.size()); end
   endtask

   task automatic test_loopback();
      logic [7:0] v [16];
      int t0, f0, o0;
      prescale = 16'd3; tready = 1'b1; clear_beats();
      f0 = fe_cnt; o0 = ovr_cnt;
      for (int i = 0; i < 16; i++) begin
         v[i] = 8'($urandom_range(0, 255));
         send_frame(v[i], 3, 1'b1, t0);
      end
      idle(60);
      checks++; if (beat_data.size() !== 16) begin errors++; $display("FAIL loop_count: got %0d expected 16", beat_data.size()); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (beat_at(i) !== v[i]) begin errors++; $display("FAIL loop_data%0d: got %h expected %h", i, beat_at(i), v[i]); end
      end
      checks++; if ((fe_cnt - f0) + (ovr_cnt - o0) !== 0) begin errors++; $display("FAIL loop_errs: got %0d expected 0", (fe_cnt - f0) + (ovr_cnt - o0)); end
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      idle(4);
      test_basic();
      test_back_to_back();
      test_overrun();
      test_frame_break();
      test_glitch();
      test_reset_mid();
      test_loopback();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
